// File: rtl/rv64g_dmem_responder.sv
// Behavioural data memory answering the core D-cache req/gnt port with a fixed grant latency.
// Optional misalign error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
`timescale 1ns/1ps
module rv64g_dmem_responder #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          dcache_req_i,
  input  logic          dcache_wr_i,
  input  logic [AW-1:0] dcache_addr_i,
  input  logic [1:0]    dcache_size_i,
  input  logic [DW-1:0] dcache_data_i,
  output logic [DW-1:0] dcache_data_o,
  output logic          dcache_gnt_o,
  output logic          dcache_err_o,
  output logic [1:0]    dbg_state_o
);

  // Handshake: the core raises req with stable wr/addr/size/data and holds it until the
  // single-cycle gnt; dropping req before gnt cancels the access with no side effects.
  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 3;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GNT = 2'd2} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            wr_q;
  logic [OW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            sel_wr;
  logic [OW-1:0]   sel_addr;
  logic [1:0]      sel_size;
  logic [DW-1:0]   sel_data;
  logic [IW-1:0]   idx;
  logic [2:0]      off;
  logic [3:0]      nbytes;
  logic [2:0]      mask;
  logic            misalign;
  logic            skip;
  logic            acc_go;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   ld_data;
  logic [DW-1:0]   wr_word;
  logic [2:0]      lane;
  logic            unused_addr;

  assign unused_addr = ^dcache_addr_i[AW-1:OW];
  assign dbg_state_o = state_q;

  // With LATENCY==1 the access completes straight out of IDLE, so it reads the live inputs.
  always_comb begin
    sel_wr   = wr_q;
    sel_addr = addr_q;
    sel_size = size_q;
    sel_data = wdata_q;
    if (state_q == S_IDLE) begin
      sel_wr   = dcache_wr_i;
      sel_addr = dcache_addr_i[OW-1:0];
      sel_size = dcache_size_i;
      sel_data = dcache_data_i;
    end
  end

  assign idx      = sel_addr[OW-1:3];
  assign off      = sel_addr[2:0];
  assign nbytes   = 4'd1 << sel_size;
  assign mask     = 3'(nbytes - 4'd1);
  assign misalign = |(off & mask);
  assign skip     = ERR_EN && misalign;
  assign rd_word  = mem[idx];

  assign acc_go = dcache_req_i &&
                  (((state_q == S_IDLE) && (LATENCY == 1)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd1)));

  // Byte lanes wrap within the word, so misaligned accesses never touch a neighbour word.
  always_comb begin
    ld_data = '0;
    wr_word = rd_word;
    lane    = '0;
    for (int i = 0; i < 8; i++) begin
      lane = off + 3'(i);
      if (4'(i) < nbytes) begin
        ld_data[i*8 +: 8]          = rd_word[{lane, 3'b000} +: 8];
        wr_word[{lane, 3'b000} +: 8] = sel_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      size_q        <= '0;
      wdata_q       <= '0;
      dcache_gnt_o  <= 1'b0;
      dcache_err_o  <= 1'b0;
      dcache_data_o <= '0;
    end else begin
      dcache_gnt_o <= acc_go;
      dcache_err_o <= acc_go && skip;
      if (acc_go && !sel_wr) dcache_data_o <= skip ? '0 : ld_data;
      case (state_q)
        S_IDLE: begin
          if (dcache_req_i) begin
            wr_q    <= dcache_wr_i;
            addr_q  <= dcache_addr_i[OW-1:0];
            size_q  <= dcache_size_i;
            wdata_q <= dcache_data_i;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? S_GNT : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!dcache_req_i) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= S_GNT;
          end
        end
        S_GNT:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Store commits on the edge that ends the grant cycle; a reset drops state out of GNT first.
  always_ff @(posedge clk_i) begin
    if (state_q == S_GNT && wr_q && !skip) mem[idx] <= wr_word;
  end

endmodule
